// File: rtl/move_pkg.sv
// Shared types and geometry defaults for sprite movement scheduling and
// sprite motion logic.
package move_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      UP    = 3'd1,
      DOWN  = 3'd2,
      LEFT  = 3'd3,
      RIGHT = 3'd4
   } dir_t;

   typedef enum logic [2:0] {
      IDLE,
      PROBE_REQ,
      WAIT_REQ,
      PROBE_CUR,
      WAIT_CUR,
      NEXT,
      COMMIT
   } state_t;

   localparam int HALF       = 13;
   localparam int X_MAX      = 404;
   localparam int Y_MAX      = 447;
   localparam int TILE_SHIFT = 4;

endpackage

// File: rtl/probe_calc.sv
// Combinational probe-point generator: maps a sprite centre and a direction
// to the maze tile just beyond the sprite edge, flagging out-of-bounds points.
module probe_calc
   import move_pkg::*;
#(
   parameter int HALF       = move_pkg::HALF,
   parameter int X_MAX      = move_pkg::X_MAX,
   parameter int Y_MAX      = move_pkg::Y_MAX,
   parameter int TILE_SHIFT = move_pkg::TILE_SHIFT
) (
   input  logic [9:0] x_i,
   input  logic [9:0] y_i,
   input  dir_t       dir_i,
   output logic [4:0] tx_o,
   output logic [4:0] ty_o,
   output logic       oob_o
);

   localparam logic signed [10:0] OFS = 11'(HALF + 1);
   localparam logic signed [10:0] XM  = 11'(X_MAX);
   localparam logic signed [10:0] YM  = 11'(Y_MAX);

   logic signed [10:0] px;
   logic signed [10:0] py;

   always_comb begin
      px = signed'({1'b0, x_i});
      py = signed'({1'b0, y_i});
      case (dir_i)
         UP:      py = py - OFS;
         DOWN:    py = py + OFS;
         LEFT:    px = px - OFS;
         RIGHT:   px = px + OFS;
         default: ;
      endcase
   end

   // Large coordinates that wrap past the 11-bit signed range read as negative.
   assign oob_o = (dir_i == NONE) || (px < 0) || (py < 0) || (px >= XM) || (py >= YM);
   assign tx_o  = 5'(unsigned'(px) >> TILE_SHIFT);
   assign ty_o  = 5'(unsigned'(py) >> TILE_SHIFT);

endmodule

// File: rtl/move_sched.sv
// Per-frame movement scheduler: walks every sprite through one shared maze
// wall-lookup port and commits step enables/directions atomically.
module move_sched
   import move_pkg::*;
#(
   parameter int N_SPRITES  = 4,
   parameter int HALF       = move_pkg::HALF,
   parameter int X_MAX      = move_pkg::X_MAX,
   parameter int Y_MAX      = move_pkg::Y_MAX,
   parameter int TILE_SHIFT = move_pkg::TILE_SHIFT,
   parameter int RD_LAT     = 1
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    frame_tick,
   input  logic [3*N_SPRITES-1:0]  req_dir,
   input  logic [10*N_SPRITES-1:0] pos_x,
   input  logic [10*N_SPRITES-1:0] pos_y,
   output logic                    maze_rd,
   output logic [4:0]              maze_tx,
   output logic [4:0]              maze_ty,
   input  logic                    maze_wall,
   output logic [N_SPRITES-1:0]    step_en,
   output logic [3*N_SPRITES-1:0]  step_dir,
   output logic                    busy,
   output logic                    done,
   output logic                    overrun
);

   localparam int             IW       = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(N_SPRITES - 1);
   localparam logic [1:0]     LAT_END  = 2'(RD_LAT - 1);

   state_t                   state_q, state_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [1:0]               lat_q, lat_d;
   logic                     busy_q, busy_d;
   logic                     overrun_q, overrun_d;
   logic [N_SPRITES-1:0]     step_en_q, step_en_d;
   logic [3*N_SPRITES-1:0]   step_dir_q, step_dir_d;
   logic [3*N_SPRITES-1:0]   last_q, last_d;

   logic [3*N_SPRITES-1:0]   req_q, req_d;
   logic [10*N_SPRITES-1:0]  px_q, px_d;
   logic [10*N_SPRITES-1:0]  py_q, py_d;
   logic [3*N_SPRITES-1:0]   new_dir_q, new_dir_d;
   logic [N_SPRITES-1:0]     new_en_q, new_en_d;

   dir_t                     req_cur;
   dir_t                     last_cur;
   dir_t                     probe_dir;
   logic                     probe_oob;
   logic                     wait_end;

   assign req_cur   = dir_t'(req_q[3*idx_q +: 3]);
   assign last_cur  = dir_t'(last_q[3*idx_q +: 3]);
   assign probe_dir = (state_q == PROBE_CUR) ? last_cur : req_cur;
   assign wait_end  = (lat_q == LAT_END);

   probe_calc #(
      .HALF       (HALF),
      .X_MAX      (X_MAX),
      .Y_MAX      (Y_MAX),
      .TILE_SHIFT (TILE_SHIFT)
   ) u_probe (
      .x_i   (px_q[10*idx_q +: 10]),
      .y_i   (py_q[10*idx_q +: 10]),
      .dir_i (probe_dir),
      .tx_o  (maze_tx),
      .ty_o  (maze_ty),
      .oob_o (probe_oob)
   );

   assign maze_rd  = ((state_q == PROBE_REQ) || (state_q == PROBE_CUR)) && !probe_oob;
   assign done     = (state_q == COMMIT);
   assign busy     = busy_q;
   assign overrun  = overrun_q;
   assign step_en  = step_en_q;
   assign step_dir = step_dir_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      lat_d      = lat_q;
      busy_d     = busy_q;
      overrun_d  = overrun_q;
      step_en_d  = step_en_q;
      step_dir_d = step_dir_q;
      last_d     = last_q;
      req_d      = req_q;
      px_d       = px_q;
      py_d       = py_q;
      new_dir_d  = new_dir_q;
      new_en_d   = new_en_q;

      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               req_d   = req_dir;
               px_d    = pos_x;
               py_d    = pos_y;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = PROBE_REQ;
            end
         end
         PROBE_REQ: begin
            lat_d   = '0;
            state_d = probe_oob ? PROBE_CUR : WAIT_REQ;
         end
         WAIT_REQ: begin
            if (wait_end) begin
               if (!maze_wall) begin
                  new_dir_d[3*idx_q +: 3] = req_cur;
                  new_en_d[idx_q]         = 1'b1;
                  state_d                 = NEXT;
               end else begin
                  state_d = PROBE_CUR;
               end
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         PROBE_CUR: begin
            lat_d = '0;
            if (last_cur == NONE) begin
               new_dir_d[3*idx_q +: 3] = NONE;
               new_en_d[idx_q]         = 1'b0;
               state_d                 = NEXT;
            end else if (probe_oob) begin
               new_dir_d[3*idx_q +: 3] = last_cur;
               new_en_d[idx_q]         = 1'b0;
               state_d                 = NEXT;
            end else begin
               state_d = WAIT_CUR;
            end
         end
         WAIT_CUR: begin
            if (wait_end) begin
               // A blocked sprite keeps its facing but stops.
               new_dir_d[3*idx_q +: 3] = last_cur;
               new_en_d[idx_q]         = !maze_wall;
               state_d                 = NEXT;
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end
         NEXT: begin
            if (idx_q == LAST_IDX) begin
               // Results become visible together with the done pulse.
               step_en_d  = new_en_q;
               step_dir_d = new_dir_q;
               last_d     = new_dir_q;
               state_d    = COMMIT;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = PROBE_REQ;
            end
         end
         COMMIT: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (frame_tick && busy_q) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         lat_q      <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         step_en_q  <= '0;
         step_dir_q <= '0;
         last_q     <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lat_q      <= lat_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         step_en_q  <= step_en_d;
         step_dir_q <= step_dir_d;
         last_q     <= last_d;
      end
   end

   always_ff @(posedge Clk) begin
      req_q     <= req_d;
      px_q      <= px_d;
      py_q      <= py_d;
      new_dir_q <= new_dir_d;
      new_en_q  <= new_en_d;
   end

endmodule
